// File: rtl/jtopl_eg_gen.sv
// Time-multiplexed ADSR envelope generator: one slot per cen, per-slot state held in a rotating ring.
// Latency: eg_pure/eg_state/pg_rst show the slot accepted on the previous cen (1 cen).
// No backpressure: cen paces the ring. Optional JTOPL_EG_CSM_EN adds csm_kon (CSM key-on OR'ed into keyon).
module jtopl_eg_gen #(
  parameter int SLOTS = 18,
  parameter int CNTW  = 15   // must be >= 14 so eg_cnt[sh+2:sh] exists for every rate
) (
  input  logic       rst,
  input  logic       clk,
  input  logic       cen,
  input  logic       zero,
  input  logic       keyon,
  input  logic [3:0] ar,
  input  logic [3:0] dr,
  input  logic [3:0] rr,
  input  logic [3:0] sl,
  input  logic       eg_type,
  input  logic       ksr,
  input  logic [3:0] keycode,
`ifdef JTOPL_EG_CSM_EN
  input  logic       csm_kon,
`endif
  output logic [9:0] eg_pure,
  output logic [1:0] eg_state,
  output logic       pg_rst
);

  localparam logic [1:0] ATTACK  = 2'd0;
  localparam logic [1:0] DECAY   = 2'd1;
  localparam logic [1:0] SUSTAIN = 2'd2;
  localparam logic [1:0] RELEASE = 2'd3;
  localparam logic [CNTW-1:0] CNT_ONE = CNTW'(1);

  logic [1:0]      st_ring  [SLOTS];
  logic [9:0]      eg_ring  [SLOTS];
  logic            kon_ring [SLOTS];
  logic [CNTW-1:0] eg_cnt;

  logic [CNTW-1:0] cnt_now;
  logic            key_eff;
  logic            kon_edge;
  logic [1:0]      st_key;
  logic [9:0]      eg_cur;
  logic [3:0]      rsel;
  logic [6:0]      rate_sum;
  logic [5:0]      rate;
  logic [7:0]      pat;
  logic [3:0]      sh;
  logic [CNTW-1:0] mask;
  logic [2:0]      idx;
  logic [4:0]      big;
  logic [3:0]      inc;
  logic [13:0]     prod;
  logic [9:0]      dec;
  logic [9:0]      diff;
  logic [9:0]      eg_att;
  logic [10:0]     sum;
  logic [9:0]      eg_add;
  logic [4:0]      sl_lim;
  logic [1:0]      st_nxt;
  logic [9:0]      eg_nxt;

  // Counter value seen by this slot: slot 0 already sees the incremented count
  always_comb begin
    cnt_now = zero ? eg_cnt + CNT_ONE : eg_cnt;
    eg_cur  = eg_ring[0];
  end

  // Key edge detection on the head entry; key-on wins over everything else
  always_comb begin
`ifdef JTOPL_EG_CSM_EN
    key_eff = keyon | csm_kon;
`else
    key_eff = keyon;
`endif
    kon_edge = key_eff & ~kon_ring[0];
    st_key   = st_ring[0];
    if (kon_edge)
      st_key = ATTACK;
    else if (!key_eff && st_ring[0] != RELEASE)
      st_key = RELEASE;
  end

  // Effective rate for the state after key handling
  always_comb begin
    rsel = rr;
    case (st_key)
      ATTACK:  rsel = ar;
      DECAY:   rsel = dr;
      SUSTAIN: rsel = eg_type ? 4'd0 : rr;
      default: rsel = rr;
    endcase
    rate_sum = {1'b0, rsel, 2'b00} + (ksr ? {3'b000, keycode} : {5'b00000, keycode[3:2]});
    if (rsel == 4'd0)
      rate = 6'd0;
    else if (rate_sum > 7'd63)
      rate = 6'd63;
    else
      rate = rate_sum[5:0];
  end

  // Increment from rate and global counter: slow rates gate on counter phase, fast rates scale up
  always_comb begin
    case (rate[1:0])
      2'd0:    pat = 8'h55;
      2'd1:    pat = 8'h57;
      2'd2:    pat = 8'h77;
      default: pat = 8'h7F;
    endcase
    sh   = 4'd11 - rate[5:2];
    mask = (CNT_ONE << sh) - CNT_ONE;
    idx  = 3'(cnt_now >> sh);
    big  = (pat[cnt_now[2:0]] ? 5'd2 : 5'd1) << rate[3:2];
    inc  = 4'd0;
    if (rate == 6'd0)
      inc = 4'd0;
    else if (rate[5:2] < 4'd12)
      inc = {3'b000, pat[idx] & ((cnt_now & mask) == '0)};
    else
      inc = (big > 5'd8) ? 4'd8 : big[3:0];
  end

  // Attenuation arithmetic: exponential attack toward 0, saturating linear rise otherwise
  always_comb begin
    prod   = {4'b0000, eg_cur} * {10'b0, inc};
    dec    = 10'(prod >> 3);
    diff   = eg_cur - dec;
    if (rate >= 6'd60)
      eg_att = 10'd0;
    else if (inc == 4'd0)
      eg_att = eg_cur;
    else if (diff == 10'd0)
      eg_att = 10'd0;
    else
      eg_att = diff - 10'd1;
    sum    = {1'b0, eg_cur} + {7'b0, inc};
    eg_add = sum[10] ? 10'h3FF : sum[9:0];
    sl_lim = (sl == 4'hF) ? 5'd31 : {1'b0, sl};
  end

  // State-based transitions, suppressed on the key-on cen
  always_comb begin
    st_nxt = st_key;
    eg_nxt = eg_add;
    case (st_key)
      ATTACK: begin
        eg_nxt = eg_att;
        if (!kon_edge && (eg_cur == 10'd0 || eg_att == 10'd0))
          st_nxt = DECAY;
      end
      DECAY: begin
        if (eg_add[9:5] >= sl_lim)
          st_nxt = SUSTAIN;
      end
      default: st_nxt = st_key;
    endcase
  end

  // Ring rotation, global counter and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SLOTS; i++) begin
        st_ring[i]  <= RELEASE;
        eg_ring[i]  <= 10'h3FF;
        kon_ring[i] <= 1'b0;
      end
      eg_cnt   <= '0;
      eg_pure  <= 10'h3FF;
      eg_state <= RELEASE;
      pg_rst   <= 1'b0;
    end else if (cen) begin
      for (int i = 0; i < SLOTS - 1; i++) begin
        st_ring[i]  <= st_ring[i+1];
        eg_ring[i]  <= eg_ring[i+1];
        kon_ring[i] <= kon_ring[i+1];
      end
      st_ring[SLOTS-1]  <= st_nxt;
      eg_ring[SLOTS-1]  <= eg_nxt;
      kon_ring[SLOTS-1] <= key_eff;
      eg_cnt   <= cnt_now;
      eg_pure  <= eg_nxt;
      eg_state <= st_nxt;
      pg_rst   <= kon_edge;
    end
  end

endmodule

// File: tb/tb_jtopl_eg_gen.sv
// Bench for jtopl_eg_gen: per-slot reference model feeds a scoreboard queue,
// directed phases on slot 0, random traffic on other slots, idle cycles and a mid-round reset.
module tb_jtopl_eg_gen;
  localparam int SLOTS = 18;
  localparam int CNTW  = 15;

  logic       rst, clk, cen, zero, keyon, eg_type, ksr;
  logic [3:0] ar, dr, rr, sl, keycode;
  logic [9:0] eg_pure;
  logic [1:0] eg_state;
  logic       pg_rst;
`ifdef JTOPL_EG_CSM_EN
  logic       csm_kon;
`endif

  jtopl_eg_gen #(.SLOTS(SLOTS), .CNTW(CNTW)) dut (
    .rst(rst), .clk(clk), .cen(cen), .zero(zero), .keyon(keyon),
    .ar(ar), .dr(dr), .rr(rr), .sl(sl), .eg_type(eg_type), .ksr(ksr), .keycode(keycode),
`ifdef JTOPL_EG_CSM_EN
    .csm_kon(csm_kon),
`endif
    .eg_pure(eg_pure), .eg_state(eg_state), .pg_rst(pg_rst)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // per-slot stimulus
  bit       s_kon [SLOTS];
  bit       s_csm [SLOTS];
  bit [3:0] s_ar [SLOTS], s_dr [SLOTS], s_rr [SLOTS], s_sl [SLOTS], s_kc [SLOTS];
  bit       s_et [SLOTS], s_ksr [SLOTS];
  bit       rnd_others;

  // reference model state
  int m_eg [SLOTS];
  int m_st [SLOTS];
  bit m_pk [SLOTS];
  int m_cnt;

  // observed outputs per slot (latest)
  int obs_eg [SLOTS];
  int obs_st [SLOTS];
  int obs_pg [SLOTS];

  typedef struct { int eg; int st; int pg; int slot; } exp_t;
  exp_t sbq[$];
  exp_t last_exp;
  int   slot;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int pat_of(input int lo);
    case (lo)
      0: return 'h55;
      1: return 'h57;
      2: return 'h77;
      default: return 'h7F;
    endcase
  endfunction

  function automatic int calc_rate(input int r, input bit k, input int kc);
    int v;
    if (r == 0) return 0;
    v = r * 4 + (k ? kc : kc / 4);
    return (v > 63) ? 63 : v;
  endfunction

  function automatic int calc_inc(input int rate, input int cnt);
    int hi, lo, p, sh, v;
    if (rate == 0) return 0;
    hi = rate / 4;
    lo = rate % 4;
    p  = pat_of(lo);
    if (hi < 12) begin
      sh = 11 - hi;
      if ((cnt % (1 << sh)) != 0) return 0;
      return (p >> ((cnt >> sh) % 8)) % 2;
    end
    v = ((p >> (cnt % 8)) % 2 == 1) ? 2 : 1;
    v = v << (hi - 12);
    return (v > 8) ? 8 : v;
  endfunction

  task automatic model_eval(input int s);
    exp_t e;
    int   st, eg, eg0, r, rate, inc, slp;
    bit   key, edge_on;
    if (s == 0) m_cnt = (m_cnt + 1) % (1 << CNTW);
    key = s_kon[s];
`ifdef JTOPL_EG_CSM_EN
    key = key | s_csm[s];
`endif
    st = m_st[s];
    eg = m_eg[s];
    eg0 = eg;
    edge_on = key && !m_pk[s];
    if (edge_on) st = 0;
    else if (!key && st != 3) st = 3;
    case (st)
      0: r = s_ar[s];
      1: r = s_dr[s];
      2: r = s_et[s] ? 0 : s_rr[s];
      default: r = s_rr[s];
    endcase
    rate = calc_rate(r, s_ksr[s], s_kc[s]);
    inc  = calc_inc(rate, m_cnt);
    if (st == 0) begin
      if (rate >= 60) eg = 0;
      else if (inc != 0) begin
        eg = eg - (eg * inc) / 8 - 1;
        if (eg < 0) eg = 0;
      end
      if (!edge_on && (eg0 == 0 || eg == 0)) st = 1;
    end else begin
      eg = eg + inc;
      if (eg > 1023) eg = 1023;
      slp = (s_sl[s] == 15) ? 31 : s_sl[s];
      if (st == 1 && (eg / 32) >= slp) st = 2;
    end
    m_eg[s] = eg;
    m_st[s] = st;
    m_pk[s] = key;
    e.eg = eg; e.st = st; e.pg = edge_on ? 1 : 0; e.slot = s;
    sbq.push_back(e);
  endtask

  task automatic tick(input bit do_cen);
    exp_t e;
    cen     = do_cen;
    zero    = do_cen ? (slot == 0) : 1'($urandom_range(0, 1));
    keyon   = s_kon[slot];
    ar      = s_ar[slot];
    dr      = s_dr[slot];
    rr      = s_rr[slot];
    sl      = s_sl[slot];
    eg_type = s_et[slot];
    ksr     = s_ksr[slot];
    keycode = s_kc[slot];
`ifdef JTOPL_EG_CSM_EN
    csm_kon = s_csm[slot];
`endif
    if (do_cen) model_eval(slot);
    @(posedge clk);
    #1;
    if (do_cen) begin
      e = sbq.pop_front();
      check($sformatf("eg_pure slot%0d", e.slot), 32'(eg_pure), e.eg);
      check($sformatf("eg_state slot%0d", e.slot), 32'(eg_state), e.st);
      check($sformatf("pg_rst slot%0d", e.slot), 32'(pg_rst), e.pg);
      obs_eg[e.slot] = eg_pure;
      obs_st[e.slot] = eg_state;
      obs_pg[e.slot] = pg_rst;
      last_exp = e;
      slot = (slot + 1) % SLOTS;
    end else begin
      check("hold eg_pure", 32'(eg_pure), last_exp.eg);
      check("hold eg_state", 32'(eg_state), last_exp.st);
      check("hold pg_rst", 32'(pg_rst), last_exp.pg);
    end
  endtask

  task automatic shuffle_others();
    for (int s = 1; s < SLOTS; s++) begin
      if ($urandom_range(0, 7) == 0) s_kon[s] = !s_kon[s];
      if ($urandom_range(0, 15) == 0) begin
        s_ar[s] = 4'($urandom_range(0, 15)); s_dr[s] = 4'($urandom_range(0, 15));
        s_rr[s] = 4'($urandom_range(0, 15)); s_sl[s] = 4'($urandom_range(0, 15));
        s_kc[s] = 4'($urandom_range(0, 15));
        s_et[s] = 1'($urandom_range(0, 1)); s_ksr[s] = 1'($urandom_range(0, 1));
      end
    end
  endtask

  task automatic run_rounds(input int n);
    for (int k = 0; k < n * SLOTS; k++) begin
      if (slot == 0 && rnd_others) shuffle_others();
      if ($urandom_range(0, 3) == 0) tick(1'b0);
      tick(1'b1);
    end
  endtask

  task automatic do_reset();
    cen = 1'b0;
    rst = 1'b1;
    for (int s = 0; s < SLOTS; s++) begin
      m_eg[s] = 1023; m_st[s] = 3; m_pk[s] = 1'b0;
      obs_eg[s] = 1023; obs_st[s] = 3; obs_pg[s] = 0;
    end
    m_cnt = 0;
    sbq.delete();
    last_exp.eg = 1023; last_exp.st = 3; last_exp.pg = 0; last_exp.slot = 0;
    slot = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst eg_pure", 32'(eg_pure), 32'h3FF);
    check("rst eg_state", 32'(eg_state), 3);
    check("rst pg_rst", 32'(pg_rst), 0);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("post-rst eg_pure", 32'(eg_pure), 32'h3FF);
    check("post-rst eg_state", 32'(eg_state), 3);
    check("post-rst pg_rst", 32'(pg_rst), 0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int r, pg_sum;
    rst = 1'b1; cen = 1'b0; zero = 1'b0; keyon = 1'b0;
    ar = 4'd0; dr = 4'd0; rr = 4'd0; sl = 4'd0; eg_type = 1'b0; ksr = 1'b0; keycode = 4'd0;
`ifdef JTOPL_EG_CSM_EN
    csm_kon = 1'b0;
`endif
    for (int s = 0; s < SLOTS; s++) begin
      s_kon[s] = 1'($urandom_range(0, 1)); s_csm[s] = 1'b0;
      s_ar[s] = 4'($urandom_range(0, 15)); s_dr[s] = 4'($urandom_range(0, 15));
      s_rr[s] = 4'($urandom_range(0, 15)); s_sl[s] = 4'($urandom_range(0, 15));
      s_kc[s] = 4'($urandom_range(0, 15));
      s_et[s] = 1'($urandom_range(0, 1)); s_ksr[s] = 1'($urandom_range(0, 1));
    end
    // slot 0 directed setup
    s_kon[0] = 1'b0; s_ar[0] = 4'd15; s_dr[0] = 4'd11; s_rr[0] = 4'd15; s_sl[0] = 4'd2;
    s_et[0] = 1'b1; s_ksr[0] = 1'b0; s_kc[0] = 4'd0;
    rnd_others = 1'b1;
    do_reset();

    run_rounds(1);
    // key-on with ar=15: immediate 0, phase reset, then DECAY next round
    s_kon[0] = 1'b1;
    run_rounds(1);
    check("kon pg_rst", obs_pg[0], 1);
    check("kon eg", obs_eg[0], 0);
    check("kon state", obs_st[0], 0);
    run_rounds(1);
    check("decay state", obs_st[0], 1);
    check("decay pg_rst", obs_pg[0], 0);

    // DECAY climbs to sl=2 -> eg 64, then frozen in SUSTAIN
    r = 0;
    while (obs_st[0] != 2 && r < 400) begin run_rounds(1); r++; end
    check("sustain reached", obs_st[0], 2);
    check("sustain eg", obs_eg[0], 64);
    run_rounds(300);
    check("sustain frozen eg", obs_eg[0], 64);
    check("sustain frozen state", obs_st[0], 2);

    // key-off with rr=15: +8 per round to 0x3FF, no wrap
    s_kon[0] = 1'b0;
    run_rounds(1);
    check("release state", obs_st[0], 3);
    check("release first eg", obs_eg[0], 72);
    r = 0;
    while (obs_eg[0] != 1023 && r < 200) begin run_rounds(1); r++; end
    check("release saturates", obs_eg[0], 1023);
    run_rounds(20);
    check("release no wrap", obs_eg[0], 1023);

    // ar=0: ATTACK holds eg, key-off goes straight to RELEASE
    s_ar[0] = 4'd0; s_kon[0] = 1'b1;
    run_rounds(1);
    check("ar0 pg_rst", obs_pg[0], 1);
    check("ar0 state", obs_st[0], 0);
    run_rounds(300);
    check("ar0 hold eg", obs_eg[0], 1023);
    check("ar0 hold state", obs_st[0], 0);
    s_kon[0] = 1'b0;
    run_rounds(1);
    check("ar0 keyoff state", obs_st[0], 3);

    // retrigger from RELEASE with a mid attack rate, then random traffic on slot 0 too
    s_ar[0] = 4'd12; s_kon[0] = 1'b1;
    run_rounds(40);
    s_ar[0] = 4'd9; s_kon[0] = 1'b0;
    run_rounds(20);

    // reset in the middle of a round
    for (int k = 0; k < 7; k++) tick(1'b1);
    do_reset();
    run_rounds(20);

`ifdef JTOPL_EG_CSM_EN
    rnd_others = 1'b0;
    for (int s = 0; s < SLOTS; s++) s_kon[s] = 1'b0;
    run_rounds(2);
    s_csm[5] = 1'b1;
    run_rounds(1);
    s_csm[5] = 1'b0;
    pg_sum = 0;
    for (int s = 0; s < SLOTS; s++) pg_sum += obs_pg[s];
    check("csm slot5 pg_rst", obs_pg[5], 1);
    check("csm slot5 state", obs_st[5], 0);
    check("csm pg_rst count", pg_sum, 1);
    run_rounds(1);
    check("csm off release", obs_st[5], 3);
`else
    pg_sum = 0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
